// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter sequencer.
package johnson_pkg;

    localparam int unsigned JOHNSON_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_STOP   = 3'd0,
        OP_RUN    = 3'd1,
        OP_STEP   = 3'd2,
        OP_BURST  = 3'd3,
        OP_CLEAR  = 3'd4,
        OP_SETDIR = 3'd5,
        OP_RSVD6  = 3'd6,
        OP_RSVD7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_e;

    // One twisted-ring advance; dir=1 walks the sequence backwards.
    function automatic logic [JOHNSON_WIDTH-1:0] johnson_next(
        input logic [JOHNSON_WIDTH-1:0] q,
        input logic                     dir
    );
        if (dir)
            return {~q[0], q[JOHNSON_WIDTH-1:1]};
        else
            return {q[JOHNSON_WIDTH-2:0], ~q[JOHNSON_WIDTH-1]};
    endfunction

endpackage

// File: rtl/johnson_seq_ctrl_prescaler.sv
// Advance pacing: ticks once every div+1 enabled cycles while active.
module johnson_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             active_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] presc_q, presc_d;

    assign tick_o = ena_i & active_i & (presc_q == div_i);

    // Next count: frozen without ena, parked at zero when idle or restarted.
    always_comb begin
        presc_d = presc_q;
        if (ena_i) begin
            if (restart_i || !active_i || tick_o)
                presc_d = '0;
            else
                presc_d = presc_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else
            presc_q <= presc_d;
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer around an 8-bit Johnson counter.
//
//   state | meaning
//   IDLE  | q held; accepts any command
//   RUN   | q advances on every prescaler tick until STOP/STEP
//   BURST | q advances on ticks for a fixed count; commands refused
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = JOHNSON_WIDTH,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, q_adv;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic tick, accept, restart, do_adv, do_clr;

    assign cmd_ready = ena & (state_q != BURST);
    assign accept    = cmd_valid & cmd_ready;

    // Package helper covers the default width; other widths use the same rule inline.
    if (WIDTH == JOHNSON_WIDTH) begin : g_pkg_next
        assign q_adv = johnson_next(q_q, dir_q);
    end else begin : g_gen_next
        assign q_adv = dir_q ? {~q_q[0], q_q[WIDTH-1:1]}
                             : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    end

    // Leaving for IDLE also parks the prescaler so the next RUN starts clean.
    johnson_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena_i     (ena),
        .active_i  (state_q != IDLE),
        .restart_i (restart | (state_d == IDLE)),
        .div_i     (div_q),
        .tick_o    (tick)
    );

    // Next-state: tick advance first (old dir/div), then the accepted command on top.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dir_d   = dir_q;
        div_d   = div_q;
        rem_d   = rem_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        restart = 1'b0;
        do_adv  = 1'b0;
        do_clr  = 1'b0;

        if (ena) begin
            if (tick) begin
                do_adv = 1'b1;
                if (state_q == BURST) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            if (accept) begin
                unique case (op_e'(cmd_op))
                    OP_STOP: state_d = IDLE;
                    OP_RUN: begin
                        div_d   = DIV_W'(cmd_arg);
                        restart = 1'b1;
                        state_d = RUN;
                    end
                    // A STEP landing on a tick edge merges with that tick's advance.
                    OP_STEP: begin
                        do_adv  = 1'b1;
                        state_d = IDLE;
                    end
                    OP_BURST: begin
                        if (cmd_arg != 8'd0) begin
                            rem_d   = CNT_W'(cmd_arg);
                            restart = 1'b1;
                            state_d = BURST;
                        end
                    end
                    OP_CLEAR:  do_clr = 1'b1;
                    OP_SETDIR: dir_d  = cmd_arg[0];
                    default: ;
                endcase
            end

            if (do_clr) begin
                q_d = '0;
            end else if (do_adv) begin
                q_d    = q_adv;
                wrap_d = (q_adv == '0);
            end
        end
    end

    // State and registered outputs; pulses drop while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            dir_q   <= 1'b0;
            div_q   <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign busy = (state_q != IDLE);
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl.
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_arg = 8'd0;
    logic [7:0] q;
    logic       busy, wrap, done;

    int checks = 0;
    int errors = 0;

    johnson_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .q         (q),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] STOP = 3'd0, RUN = 3'd1, STEP = 3'd2, BURST = 3'd3,
                           CLEAR = 3'd4, SETDIR = 3'd5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        ena       = 1'b1;
        rst_n     = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        #1;
    endtask

    // Reference model: position k along the 2*W-long ring, plus mode bookkeeping.
    int m_k, m_dir, m_div, m_mode, m_since, m_rem, m_wrap, m_done;

    function automatic logic [7:0] idx2q(input int k);
        logic [7:0] r;
        if (k <= 8) r = 8'((32'd1 << k) - 1);
        else        r = 8'(32'hFF << (k - 8));
        return r;
    endfunction

    task automatic model_reset();
        m_k = 0; m_dir = 0; m_div = 0; m_mode = 0;
        m_since = 0; m_rem = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit v, input int op, input int arg, input bit en);
        bit tick, acc, adv, clr;
        int nmode, ndir, ndiv;
        m_wrap = 0;
        m_done = 0;
        if (!en) return;
        tick = 0; adv = 0; clr = 0;
        nmode = m_mode; ndir = m_dir; ndiv = m_div;
        if (m_mode != 0) begin
            m_since++;
            if (m_since == m_div + 1) begin
                tick = 1;
                m_since = 0;
            end
        end
        acc = v && (m_mode != 2);
        adv = tick;
        if (m_mode == 2 && tick) begin
            m_rem--;
            if (m_rem == 0) begin
                nmode = 0;
                m_done = 1;
            end
        end
        if (acc) begin
            case (op)
                0: nmode = 0;
                1: begin ndiv = arg; m_since = 0; nmode = 1; end
                2: begin adv = 1; nmode = 0; end
                3: if (arg != 0) begin m_rem = arg; m_since = 0; nmode = 2; end
                4: clr = 1;
                5: ndir = arg % 2;
                default: ;
            endcase
        end
        if (clr) m_k = 0;
        else if (adv) begin
            m_k = m_dir ? (m_k + 15) % 16 : (m_k + 1) % 16;
            m_wrap = (m_k == 0);
        end
        m_dir = ndir;
        m_div = ndiv;
        if (nmode == 0) m_since = 0;
        m_mode = nmode;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] arg;
        logic [7:0] q;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] fwd [16];
        logic [7:0] prev;
        int lo, dn, chg;
        fwd = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        for (int i = 0; i < 16; i++)
            tbl.push_back('{STEP, 8'd0, fwd[i], (i == 15)});
        tbl.push_back('{SETDIR, 8'd1, 8'h00, 1'b0});
        tbl.push_back('{STEP,   8'd0, 8'h80, 1'b0});
        tbl.push_back('{STEP,   8'd0, 8'hC0, 1'b0});
        tbl.push_back('{CLEAR,  8'd0, 8'h00, 1'b0});
        tbl.push_back('{SETDIR, 8'd0, 8'h00, 1'b0});
        tbl.push_back('{STEP,   8'd0, 8'h01, 1'b0});
        tbl.push_back('{SETDIR, 8'd1, 8'h01, 1'b0});
        tbl.push_back('{STEP,   8'd0, 8'h00, 1'b1});

        // Reset values
        cyc(2);
        rst_n = 1'b1;
        #1;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Single-step vectors
        foreach (tbl[i]) begin
            cmd(tbl[i].op, tbl[i].arg);
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // RUN div=2: first advance three edges after accept, then every third
        cmd(SETDIR, 8'd0);
        cmd(RUN, 8'd2);
        chk("run_busy", 32'(busy), 32'd1);
        cyc(1); chk("run_e1", 32'(q), 32'h00);
        cyc(1); chk("run_e2", 32'(q), 32'h00);
        cyc(1); chk("run_e3", 32'(q), 32'h01);
        cyc(2); chk("run_e5", 32'(q), 32'h01);
        cyc(1); chk("run_e6", 32'(q), 32'h03);
        cyc(1);
        cmd(STOP, 8'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        cyc(4);
        chk("stop_hold", 32'(q), 32'h03);

        // ena low mid-RUN freezes q and prescaler
        cmd(RUN, 8'd2);
        cyc(3);
        chk("ena_pre", 32'(q), 32'h07);
        ena = 1'b0;
        #1;
        chk("ena_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("ena_frz_q", 32'(q), 32'h07);
            chk("ena_frz_rdy", 32'(cmd_ready), 32'd0);
        end
        ena = 1'b1;
        cyc(2); chk("ena_resume2", 32'(q), 32'h07);
        cyc(1); chk("ena_resume3", 32'(q), 32'h0F);

        // CLEAR and STEP on div=0 tick edges
        cmd(RUN, 8'd0);
        chk("rerun_q", 32'(q), 32'h0F);
        cyc(2);
        chk("run0_q", 32'(q), 32'h3F);
        cmd(CLEAR, 8'd0);
        chk("clr_q", 32'(q), 32'h00);
        chk("clr_wrap", 32'(wrap), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("clr_next", 32'(q), 32'h01);
        cmd(STEP, 8'd0);
        chk("step_tick_q", 32'(q), 32'h03);
        chk("step_tick_busy", 32'(busy), 32'd0);

        // BURST of 5 at div=0
        cmd(RUN, 8'd0);
        cmd(BURST, 8'd5);
        chk("burst_first", 32'(q), 32'h07);
        lo = 0; dn = 0; chg = 0; prev = q;
        for (int i = 0; i < 10; i++) begin
            if (!cmd_ready) lo++;
            if (done) dn++;
            if (q !== prev) chg++;
            prev = q;
            cyc(1);
        end
        chk("burst_rdy_low", 32'(lo), 32'd5);
        chk("burst_done_cnt", 32'(dn), 32'd1);
        chk("burst_advances", 32'(chg), 32'd5);
        chk("burst_q", 32'(q), 32'hFF);
        chk("burst_rdy_back", 32'(cmd_ready), 32'd1);
        cmd(BURST, 8'd0);
        chk("burst0_busy", 32'(busy), 32'd0);
        chk("burst0_q", 32'(q), 32'hFF);

        // Asynchronous reset mid-BURST
        cmd(RUN, 8'd3);
        cmd(BURST, 8'd10);
        cyc(5);
        chk("midb_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(q), 32'h00);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        cyc(1);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (done) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);

        // Randomised commands against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bit v, en;
            int op, arg;
            v   = ($urandom_range(0, 2) != 0);
            op  = $urandom_range(0, 7);
            arg = $urandom_range(0, 5);
            en  = ($urandom_range(0, 9) != 0);
            cmd_valid = v;
            cmd_op    = 3'(op);
            cmd_arg   = 8'(arg);
            ena       = en;
            model_edge(v, op, arg, en);
            cyc(1);
            chk("rnd_q", 32'(q), 32'(idx2q(m_k)));
            chk("rnd_busy", 32'(busy), 32'(m_mode != 0));
            chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_ready", 32'(cmd_ready), 32'(en && m_mode != 2));
        end
        cmd_valid = 1'b0;
        ena = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
